// File: rtl/sc_opsequencer_pkg.sv
// Shared constants for the operation sequencer: FSM encoding, idle/NOP control
// codes and default field widths.
package sc_opsequencer_pkg;

   localparam int DEC_SEL_W   = 3;
   localparam int MUX_SEL_W   = 3;
   localparam int ALU_SEL_W   = 4;
   localparam int SHIFT_SEL_W = 2;
   localparam int SHIFT_CNT_W = 4;

   localparam logic [2:0] DEC_NOP    = 3'b111;
   localparam logic [2:0] MUX_IDLE   = 3'b000;
   localparam logic [3:0] ALU_PASS   = 4'b0000;
   localparam logic [1:0] SHIFT_HOLD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_LOAD  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/sc_opsequencer_downcounter.sv
// Loadable down-counter that times the SHIFT phase; saturates at zero so a
// stray enable can never wrap it.
module SC_DOWNCOUNTER #(
   parameter int WIDTH = 4
) (
   input  logic             gclk,
   input  logic             grst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = load_val;
      else if (enable && (count_q != '0))
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge gclk) begin
      if (!grst_n) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/sc_opsequencer.sv
// Command sequencer for the register/ALU/shifter datapath: accepts one command
// in IDLE and walks it through CLEAR or LOAD[/SHIFT]/WRITE, then pulses done.
import sc_opsequencer_pkg::*;

module sc_opsequencer #(
   parameter int DATAWIDTH_DECODER_SELECTION    = DEC_SEL_W,
   parameter int DATAWIDTH_MUX_SELECTION        = MUX_SEL_W,
   parameter int DATAWIDTH_ALU_SELECTION        = ALU_SEL_W,
   parameter int DATAWIDTH_REGSHIFTER_SELECTION = SHIFT_SEL_W,
   parameter int DATAWIDTH_SHIFTCOUNT           = SHIFT_CNT_W
) (
   input  logic SC_OPSEQUENCER_CLOCK_50,
   input  logic SC_OPSEQUENCER_RESET_InLow,
   input  logic SC_OPSEQUENCER_cmdvalid_InHigh,
   output logic SC_OPSEQUENCER_cmdready_OutHigh,
   input  logic SC_OPSEQUENCER_cmdclear_InHigh,
   input  logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_OPSEQUENCER_cmdaluop_InBUS,
   input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_OPSEQUENCER_cmdsrcA_InBUS,
   input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_OPSEQUENCER_cmdsrcB_InBUS,
   input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_OPSEQUENCER_cmddst_InBUS,
   input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_OPSEQUENCER_cmdshiftmode_InBUS,
   input  logic [DATAWIDTH_SHIFTCOUNT-1:0]           SC_OPSEQUENCER_cmdshiftcount_InBUS,
   input  logic SC_OPSEQUENCER_overflow_InLow,
   input  logic SC_OPSEQUENCER_carry_InLow,
   input  logic SC_OPSEQUENCER_negative_InLow,
   input  logic SC_OPSEQUENCER_zero_InLow,
   output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_OPSEQUENCER_decoderclearselection_OutBUS,
   output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_OPSEQUENCER_decoderloadselection_OutBUS,
   output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_OPSEQUENCER_muxselectionBUSA_OutBUS,
   output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_OPSEQUENCER_muxselectionBUSB_OutBUS,
   output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_OPSEQUENCER_aluselection_OutBUS,
   output logic SC_OPSEQUENCER_regSHIFTERclear_OutLow,
   output logic SC_OPSEQUENCER_regSHIFTERload_OutLow,
   output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_OPSEQUENCER_regSHIFTERshiftselection_OutBUS,
   output logic SC_OPSEQUENCER_done_OutHigh,
   output logic [3:0] SC_OPSEQUENCER_flags_OutBUS
);

   localparam logic [DATAWIDTH_DECODER_SELECTION-1:0]    DEC_NOP_W  = DATAWIDTH_DECODER_SELECTION'(DEC_NOP);
   localparam logic [DATAWIDTH_MUX_SELECTION-1:0]        MUX_IDLE_W = DATAWIDTH_MUX_SELECTION'(MUX_IDLE);
   localparam logic [DATAWIDTH_ALU_SELECTION-1:0]        ALU_PASS_W = DATAWIDTH_ALU_SELECTION'(ALU_PASS);
   localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] HOLD_W     = DATAWIDTH_REGSHIFTER_SELECTION'(SHIFT_HOLD);

   state_t state_q, state_d;
   logic                                      clear_q, clear_d;
   logic [DATAWIDTH_ALU_SELECTION-1:0]        aluop_q, aluop_d;
   logic [DATAWIDTH_MUX_SELECTION-1:0]        srca_q, srca_d, srcb_q, srcb_d;
   logic [DATAWIDTH_DECODER_SELECTION-1:0]    dst_q, dst_d;
   logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] mode_q, mode_d;
   logic [3:0]                                flags_q, flags_d;

   logic                            cnt_load, cnt_en, cnt_zero;
   logic [DATAWIDTH_SHIFTCOUNT-1:0] cnt_load_val, cnt_val;
   logic [DATAWIDTH_DECODER_SELECTION-1:0] dst_strobe;

   // Out-of-range destinations fall back to NOP but still run the sequence.
   assign dst_strobe = (32'(dst_q) >= 32'd4) ? DEC_NOP_W : dst_q;

   // HOLD mode and clear commands never shift, so the counter is loaded with 0.
   assign cnt_load_val = (SC_OPSEQUENCER_cmdclear_InHigh ||
                          (SC_OPSEQUENCER_cmdshiftmode_InBUS == HOLD_W)) ? '0
                         : SC_OPSEQUENCER_cmdshiftcount_InBUS;

   SC_DOWNCOUNTER #(.WIDTH(DATAWIDTH_SHIFTCOUNT)) u_shift_cnt (
      .gclk     (SC_OPSEQUENCER_CLOCK_50),
      .grst_n   (SC_OPSEQUENCER_RESET_InLow),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .enable   (cnt_en),
      .count    (cnt_val),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      clear_d  = clear_q;
      aluop_d  = aluop_q;
      srca_d   = srca_q;
      srcb_d   = srcb_q;
      dst_d    = dst_q;
      mode_d   = mode_q;
      flags_d  = flags_q;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      SC_OPSEQUENCER_cmdready_OutHigh                = 1'b0;
      SC_OPSEQUENCER_done_OutHigh                    = 1'b0;
      SC_OPSEQUENCER_decoderclearselection_OutBUS    = DEC_NOP_W;
      SC_OPSEQUENCER_decoderloadselection_OutBUS     = DEC_NOP_W;
      SC_OPSEQUENCER_muxselectionBUSA_OutBUS         = MUX_IDLE_W;
      SC_OPSEQUENCER_muxselectionBUSB_OutBUS         = MUX_IDLE_W;
      SC_OPSEQUENCER_aluselection_OutBUS             = ALU_PASS_W;
      SC_OPSEQUENCER_regSHIFTERclear_OutLow          = 1'b1;
      SC_OPSEQUENCER_regSHIFTERload_OutLow           = 1'b1;
      SC_OPSEQUENCER_regSHIFTERshiftselection_OutBUS = HOLD_W;
      case (state_q)
         ST_IDLE: begin
            SC_OPSEQUENCER_cmdready_OutHigh = 1'b1;
            if (SC_OPSEQUENCER_cmdvalid_InHigh) begin
               clear_d  = SC_OPSEQUENCER_cmdclear_InHigh;
               aluop_d  = SC_OPSEQUENCER_cmdaluop_InBUS;
               srca_d   = SC_OPSEQUENCER_cmdsrcA_InBUS;
               srcb_d   = SC_OPSEQUENCER_cmdsrcB_InBUS;
               dst_d    = SC_OPSEQUENCER_cmddst_InBUS;
               mode_d   = SC_OPSEQUENCER_cmdshiftmode_InBUS;
               cnt_load = 1'b1;
               state_d  = SC_OPSEQUENCER_cmdclear_InHigh ? ST_CLEAR : ST_LOAD;
            end
         end
         ST_CLEAR: begin
            SC_OPSEQUENCER_decoderclearselection_OutBUS = dst_strobe;
            state_d = ST_DONE;
         end
         ST_LOAD: begin
            SC_OPSEQUENCER_muxselectionBUSA_OutBUS = srca_q;
            SC_OPSEQUENCER_muxselectionBUSB_OutBUS = srcb_q;
            SC_OPSEQUENCER_aluselection_OutBUS     = aluop_q;
            SC_OPSEQUENCER_regSHIFTERload_OutLow   = 1'b0;
            flags_d = ~{SC_OPSEQUENCER_overflow_InLow, SC_OPSEQUENCER_carry_InLow,
                        SC_OPSEQUENCER_negative_InLow, SC_OPSEQUENCER_zero_InLow};
            state_d = cnt_zero ? ST_WRITE : ST_SHIFT;
         end
         ST_SHIFT: begin
            // Counter still holds the cycles left including this one.
            SC_OPSEQUENCER_regSHIFTERshiftselection_OutBUS = mode_q;
            cnt_en = 1'b1;
            if (cnt_val == DATAWIDTH_SHIFTCOUNT'(1)) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            SC_OPSEQUENCER_decoderloadselection_OutBUS = dst_strobe;
            SC_OPSEQUENCER_muxselectionBUSA_OutBUS     = srca_q;
            SC_OPSEQUENCER_muxselectionBUSB_OutBUS     = srcb_q;
            SC_OPSEQUENCER_aluselection_OutBUS         = aluop_q;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            SC_OPSEQUENCER_done_OutHigh = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge SC_OPSEQUENCER_CLOCK_50) begin
      if (!SC_OPSEQUENCER_RESET_InLow) begin
         state_q <= ST_IDLE;
         clear_q <= 1'b0;
         aluop_q <= '0;
         srca_q  <= '0;
         srcb_q  <= '0;
         dst_q   <= '0;
         mode_q  <= '0;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         clear_q <= clear_d;
         aluop_q <= aluop_d;
         srca_q  <= srca_d;
         srcb_q  <= srcb_d;
         dst_q   <= dst_d;
         mode_q  <= mode_d;
         flags_q <= flags_d;
      end
   end

   assign SC_OPSEQUENCER_flags_OutBUS = flags_q;

endmodule

// File: doc/sc_opsequencer.md
SC_OPSEQUENCER -- requirements
Module: sc_opsequencer

Interface
REQ-001 The block SHALL have parameter DATAWIDTH_DECODER_SELECTION, default 3, the register-select code width.
REQ-002 The block SHALL have parameter DATAWIDTH_MUX_SELECTION, default 3, the bus A/B source-select width.
REQ-003 The block SHALL have parameter DATAWIDTH_ALU_SELECTION, default 4, the ALU opcode width.
REQ-004 The block SHALL have parameter DATAWIDTH_REGSHIFTER_SELECTION, default 2, the shift-mode width.
REQ-005 The block SHALL have parameter DATAWIDTH_SHIFTCOUNT, default 4, the shift repeat count width.
REQ-006 The block SHALL have these ports:
- SC_OPSEQUENCER_CLOCK_50  in  1  the single clock.
- SC_OPSEQUENCER_RESET_InLow  in  1  synchronous, active-low reset.
- SC_OPSEQUENCER_cmdvalid_InHigh  in  1  command valid.
- SC_OPSEQUENCER_cmdready_OutHigh  out  1  command accepted when high with valid.
- SC_OPSEQUENCER_cmdclear_InHigh  in  1  1 = clear-register command, 0 = ALU command.
- SC_OPSEQUENCER_cmdaluop_InBUS  in  DATAWIDTH_ALU_SELECTION  ALU opcode.
- SC_OPSEQUENCER_cmdsrcA_InBUS / cmdsrcB_InBUS  in  DATAWIDTH_MUX_SELECTION  bus A/B sources.
- SC_OPSEQUENCER_cmddst_InBUS  in  DATAWIDTH_DECODER_SELECTION  destination register.
- SC_OPSEQUENCER_cmdshiftmode_InBUS  in  DATAWIDTH_REGSHIFTER_SELECTION  shift mode.
- SC_OPSEQUENCER_cmdshiftcount_InBUS  in  DATAWIDTH_SHIFTCOUNT  number of shift cycles.
- SC_OPSEQUENCER_overflow_InLow / carry_InLow / negative_InLow / zero_InLow  in  1 each  datapath flags, active-low.
- SC_OPSEQUENCER_decoderclearselection_OutBUS / decoderloadselection_OutBUS  out  DATAWIDTH_DECODER_SELECTION.
- SC_OPSEQUENCER_muxselectionBUSA_OutBUS / muxselectionBUSB_OutBUS  out  DATAWIDTH_MUX_SELECTION.
- SC_OPSEQUENCER_aluselection_OutBUS  out  DATAWIDTH_ALU_SELECTION.
- SC_OPSEQUENCER_regSHIFTERclear_OutLow / regSHIFTERload_OutLow  out  1 each, active-low.
- SC_OPSEQUENCER_regSHIFTERshiftselection_OutBUS  out  DATAWIDTH_REGSHIFTER_SELECTION.
- SC_OPSEQUENCER_done_OutHigh  out  1  one-cycle completion pulse.
- SC_OPSEQUENCER_flags_OutBUS  out  4  {overflow, carry, negative, zero}, active-high.

Function
REQ-007 The FSM SHALL have states IDLE, CLEAR, LOAD, SHIFT, WRITE and DONE; cmdready_OutHigh SHALL be 1 only in IDLE.
REQ-008 On a clock edge with valid=1 in IDLE, the block SHALL register all cmd* fields; inputs outside that edge SHALL be ignored.
REQ-009 Transitions SHALL be:
- IDLE->CLEAR when cmdclear=1; IDLE->LOAD when cmdclear=0.
- LOAD->SHIFT when count>0, else LOAD->WRITE.
- SHIFT->WRITE after exactly count cycles.
- CLEAR->DONE; WRITE->DONE; DONE->IDLE.
REQ-010 In CLEAR, decoderclearselection SHALL equal dst for one cycle.
REQ-011 In LOAD, muxA/muxB/aluselection SHALL equal srcA/srcB/aluop and regSHIFTERload_OutLow SHALL be 0.
REQ-012 In SHIFT, shiftselection SHALL equal shiftmode; a 4-bit down-counter loaded with count SHALL decrement once per SHIFT cycle.
REQ-013 In WRITE, decoderloadselection SHALL equal dst, with muxA/muxB/aluselection held as in LOAD.
REQ-014 Idle codes, driven in every state not listed above, SHALL be:
- decoder NOP 3'b111
- mux 3'b000
- ALU pass 4'b0000
- shift HOLD 2'b11
- regSHIFTER clear/load 1
REQ-015 Flags SHALL be inverted and captured into flags_OutBUS on the edge leaving LOAD, and held otherwise (CLEAR does not update them).
REQ-016 Latency SHALL be accept-edge to done=1 of 3+count cycles for ALU commands and 2 cycles for clear commands; done SHALL be high for exactly the DONE cycle.
REQ-017 shiftmode=HOLD SHALL force count to 0.
REQ-018 dst>=4 SHALL suppress the decoder strobe (NOP) while the sequence and done pulse still run.
REQ-019 count=15 SHALL yield exactly 15 SHIFT cycles, with no wrap.

Reset
REQ-020 With RESET_InLow=0 at a clock edge, the state SHALL go to IDLE from any state, including mid-SHIFT.
REQ-021 Reset SHALL clear the counter and the command registers.
REQ-022 Reset SHALL set flags_OutBUS=4'b0000 and done=0, and drive all controls to the idle codes of REQ-014; ready=1 after reset release.

Structure
REQ-023 A shared package SHALL hold the state encoding, idle/NOP codes, HOLD shift code and width constants.
REQ-024 One sub-module, SC_DOWNCOUNTER (load, enable, zero flag), SHALL implement the shift counter.

Verification
REQ-025 ALU command aluop=4'b0001, srcA=1, srcB=2, dst=3, count=0 -> LOAD one cycle with load_OutLow=0, WRITE decoderload=3, done 3 cycles after accept.
REQ-026 count=5, mode=2'b01 -> exactly 5 cycles shiftselection=01, done 8 cycles after accept.
REQ-027 Clear command, dst=2 -> decoderclearselection=2 for one cycle, done 2 cycles after accept, flags unchanged.
REQ-028 valid held high for 20 cycles with count=3 -> exactly 3 commands accepted, ready low between accepts.
REQ-029 Reset asserted in the 3rd SHIFT cycle of count=10 -> next cycle IDLE, idle codes, flags 0, no done pulse.
REQ-030 Datapath flags zero_InLow=0, carry_InLow=0 during LOAD -> flags_OutBUS=4'b0101 until the next ALU command.
